// File: rtl/fifo_fwft_pkg.sv
// fifo_fwft_pkg: shared types for the first-word-fall-through FIFO
package fifo_fwft_pkg;
  typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP, OP_BOTH} fifo_op_e;
endpackage

// File: rtl/simple_dpram_sclk.sv
// simple_dpram_sclk: single-clock dual-port RAM with registered read and optional write-through bypass
module simple_dpram_sclk #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter bit ENABLE_BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_q;
  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_q <= mem[rd_addr_i];
  end
  if (ENABLE_BYPASS) begin : g_byp
    logic                  byp_q;
    logic [DATA_WIDTH-1:0] byp_data_q;
    always_ff @(posedge clk) begin
      if (rd_en_i) byp_q <= wr_en_i && (rd_addr_i == wr_addr_i);
      if (rd_en_i) byp_data_q <= wr_data_i;
    end
    assign rd_data_o = byp_q ? byp_data_q : rd_q;
  end else begin : g_nobyp
    assign rd_data_o = rd_q;
  end
endmodule

// File: rtl/fifo_fwft.sv
// fifo_fwft: single-clock first-word-fall-through FIFO with occupancy, thresholds,
// sticky error flags and synchronous flush
module fifo_fwft
  import fifo_fwft_pkg::*;
#(
  parameter int DEPTH_WIDTH = 4,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic [DATA_WIDTH-1:0]  wr_data_i,
  input  logic                   wr_en_i,
  output logic [DATA_WIDTH-1:0]  rd_data_o,
  output logic                   rd_valid_o,
  input  logic                   rd_en_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [DEPTH_WIDTH:0]   count_o,
  input  logic [DEPTH_WIDTH:0]   af_thresh_i,
  input  logic [DEPTH_WIDTH:0]   ae_thresh_i,
  output logic                   almost_full_o,
  output logic                   almost_empty_o,
  output logic                   overflow_o,
  output logic                   underflow_o
);
  localparam int PW    = DEPTH_WIDTH + 1;
  localparam int DEPTH = 2**DEPTH_WIDTH;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic head_valid_q, head_valid_d, head_sel_q;
  logic full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
  logic push, pop, head_free, ram_empty, ram_rd, ram_wr, direct;
  logic [DATA_WIDTH-1:0] byp_q, ram_dout;
  fifo_op_e op;
  // The head word lives either in the RAM read register or in the direct-load register;
  // the RAM only holds words behind the head.
  always_comb begin
    pop          = rd_en_i & head_valid_q;
    push         = wr_en_i & (!full_q | rd_en_i);
    head_free    = !head_valid_q | pop;
    ram_empty    = wr_ptr_q == rd_ptr_q;
    ram_rd       = head_free & !ram_empty;
    direct       = head_free & ram_empty & push;
    ram_wr       = push & !direct;
    head_valid_d = ram_rd | direct | (head_valid_q & !pop);
    rd_ptr_d     = rd_ptr_q + PW'(ram_rd);
    wr_ptr_d     = wr_ptr_q + PW'(ram_wr);
    op           = fifo_op_e'({pop, push});
    count_d      = op == OP_PUSH ? count_q + 1'b1 : op == OP_POP ? count_q - 1'b1 : count_q;
  end
  simple_dpram_sclk #(
    .ADDR_WIDTH    (DEPTH_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .ENABLE_BYPASS (0)
  ) u_ram (
    .clk       (clk),
    .rd_en_i   (ram_rd),
    .rd_addr_i (rd_ptr_q[DEPTH_WIDTH-1:0]),
    .rd_data_o (ram_dout),
    .wr_en_i   (ram_wr),
    .wr_addr_i (wr_ptr_q[DEPTH_WIDTH-1:0]),
    .wr_data_i (wr_data_i)
  );
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      af_q         <= 1'b0;
      ae_q         <= 1'b1;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      full_q       <= count_d == PW'(DEPTH);
      empty_q      <= count_d == '0;
      af_q         <= count_d >= af_thresh_i;
      ae_q         <= count_d <= ae_thresh_i;
      ovf_q        <= ovf_q | (wr_en_i & !push);
      unf_q        <= unf_q | (rd_en_i & !head_valid_q);
    end
  end
  always_ff @(posedge clk) begin
    if (ram_rd) head_sel_q <= 1'b1;
    else if (direct) head_sel_q <= 1'b0;
    if (direct) byp_q <= wr_data_i;
  end
  assign rd_data_o      = head_sel_q ? ram_dout : byp_q;
  assign rd_valid_o     = head_valid_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign count_o        = count_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;
endmodule

// File: tb/tb_fifo_fwft.sv
// tb_fifo_fwft: directed self-checking bench for fifo_fwft (depth 4, 8-bit words)
module tb_fifo_fwft;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush_i = 1'b0;
  logic [7:0] wr_data_i = '0;
  logic       wr_en_i = 1'b0;
  logic [7:0] rd_data_o;
  logic       rd_valid_o;
  logic       rd_en_i = 1'b0;
  logic       full_o, empty_o;
  logic [2:0] count_o;
  logic [2:0] af_thresh_i = 3'd3;
  logic [2:0] ae_thresh_i = 3'd1;
  logic       almost_full_o, almost_empty_o, overflow_o, underflow_o;
  int errors = 0;
  int checks = 0;
  fifo_fwft #(.DEPTH_WIDTH(2), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .wr_data_i(wr_data_i), .wr_en_i(wr_en_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_en_i(rd_en_i),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
    .af_thresh_i(af_thresh_i), .ae_thresh_i(ae_thresh_i),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );
  always #5 clk = ~clk;
  task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic fl);
    wr_en_i   = wr;
    wr_data_i = d;
    rd_en_i   = rd;
    flush_i   = fl;
    @(posedge clk);
    #1;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    flush_i = 1'b0;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_state(input string tag, input logic [2:0] cnt, input logic [6:0] flags);
    chk({tag, ".count"}, 32'(count_o), 32'(cnt));
    chk({tag, ".flags{v,f,e,af,ae,ov,un}"},
        32'({rd_valid_o, full_o, empty_o, almost_full_o, almost_empty_o, overflow_o, underflow_o}),
        32'(flags));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_state("reset", 3'd0, 7'b0010100);
    step(1, 8'hA1, 0, 0);
    chk("fwft.data", 32'(rd_data_o), 32'hA1);
    chk_state("fwft", 3'd1, 7'b1000100);
    step(0, 8'h00, 1, 0);
    chk_state("fwft_pop", 3'd0, 7'b0010100);
    for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 0, 0);
    chk_state("fill", 3'd4, 7'b1101000);
    step(1, 8'h14, 0, 0);
    chk_state("overflow", 3'd4, 7'b1101010);
    for (int i = 0; i < 4; i++) begin
      chk("drain.data", 32'(rd_data_o), 32'(8'h10 + i));
      chk("drain.valid", 32'(rd_valid_o), 32'd1);
      step(0, 8'h00, 1, 0);
    end
    chk_state("drained", 3'd0, 7'b0010110);
    step(0, 8'h00, 0, 1);
    chk_state("flush_clear", 3'd0, 7'b0010100);
    for (int i = 0; i < 4; i++) step(1, 8'(8'h20 + i), 0, 0);
    chk("full_rw.head", 32'(rd_data_o), 32'h20);
    step(1, 8'h24, 1, 0);
    chk_state("full_rw", 3'd4, 7'b1101000);
    for (int i = 0; i < 4; i++) begin
      chk("full_rw.drain", 32'(rd_data_o), 32'(8'h21 + i));
      step(0, 8'h00, 1, 0);
    end
    chk_state("full_rw_done", 3'd0, 7'b0010100);
    for (int i = 0; i < 3; i++) step(1, 8'(8'h30 + i), 0, 0);
    for (int i = 0; i < 20; i++) begin
      chk("stream.data", 32'(rd_data_o), 32'(8'h30 + i));
      step(1, 8'(8'h33 + i), 1, 0);
    end
    chk_state("stream", 3'd3, 7'b1001000);
    for (int i = 0; i < 3; i++) begin
      chk("stream.tail", 32'(rd_data_o), 32'(8'h44 + i));
      step(0, 8'h00, 1, 0);
    end
    chk_state("stream_done", 3'd0, 7'b0010100);
    step(1, 8'h41, 0, 0);
    chk_state("thr1", 3'd1, 7'b1000100);
    step(1, 8'h42, 0, 0);
    chk_state("thr2", 3'd2, 7'b1000000);
    step(1, 8'h43, 0, 0);
    chk_state("thr3", 3'd3, 7'b1001000);
    ae_thresh_i = 3'd3;
    step(0, 8'h00, 0, 0);
    chk_state("ae_retune", 3'd3, 7'b1001100);
    ae_thresh_i = 3'd1;
    step(0, 8'h00, 0, 1);
    chk_state("flush2", 3'd0, 7'b0010100);
    step(0, 8'h00, 1, 0);
    chk_state("underflow", 3'd0, 7'b0010101);
    step(1, 8'h50, 1, 0);
    chk_state("unf_push", 3'd1, 7'b1000101);
    chk("unf_push.data", 32'(rd_data_o), 32'h50);
    step(1, 8'h61, 0, 0);
    step(1, 8'h62, 0, 0);
    chk_state("pre_flush", 3'd3, 7'b1001001);
    step(1, 8'h55, 0, 1);
    chk_state("flush_push", 3'd0, 7'b0010100);
    step(1, 8'h66, 0, 0);
    chk("post_flush.data", 32'(rd_data_o), 32'h66);
    chk_state("post_flush", 3'd1, 7'b1000100);
    step(1, 8'h67, 0, 0);
    rst = 1'b1;
    step(1, 8'h68, 1, 1);
    rst = 1'b0;
    chk_state("mid_rst", 3'd0, 7'b0010100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
